// File: rtl/ssp_fifo_pkg.sv
// Shared constants and helpers for the SSP transmit/receive FIFOs.
// Holds default geometry, level-width helper and the push/pop op encoding.
package ssp_fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   // Level counter must hold 0..DEPTH inclusive, hence one extra bit.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/ssp_fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage for the SSP FIFOs.
// Synchronous write, asynchronous read, no reset on the array.
module ssp_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: store one word per accepted push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_tx_fifo_param.sv
// Parametrised SSP transmit FIFO: APB pushes, serialiser pops a show-ahead head.
// Tracks occupancy, raises a watermark interrupt and a sticky overflow flag.
module ssp_tx_fifo_param
   import ssp_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              PCLK_TX,
   input  logic              CLEAR_TX,
   input  logic              PSEL_TX,
   input  logic              PWRITE_TX,
   input  logic [DATA_W-1:0] PWDATA_TX,
   input  logic              TX_RD,
   input  logic [AW:0]       TX_WMARK,
   input  logic              TX_INTR_EN,
   input  logic              TX_OVF_CLR,
   output logic [DATA_W-1:0] TxData,
   output logic              TX_VALID,
   output logic              TX_FULL,
   output logic [AW:0]       TX_LEVEL,
   output logic              SSPTXINTR,
   output logic              TX_OVF
);

   localparam int LW = lvl_w(DEPTH);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              intr_q, intr_d;

   logic              push_req;
   logic              empty;
   logic              full;
   logic              pop_ok;
   logic              push_ok;
   fifo_op_e          op;
   logic [DATA_W-1:0] head;

   assign push_req = PSEL_TX & PWRITE_TX;
   assign empty    = (level_q == '0);
   assign full     = (level_q == LVL_FULL);
   assign pop_ok   = TX_RD & ~empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign push_ok  = push_req & (~full | pop_ok);
   assign op       = fifo_op_e'({push_ok, pop_ok});

   ssp_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (PCLK_TX),
      .we    (push_ok & ~CLEAR_TX),
      .waddr (wr_ptr_q),
      .wdata (PWDATA_TX),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

   // Next-state for pointers, level, overflow flag and interrupt.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case (op)
         OP_PUSH: level_d = level_q + LVL_ONE;
         OP_POP:  level_d = level_q - LVL_ONE;
         OP_BOTH: level_d = level_q;
         OP_IDLE: level_d = level_q;
         default: level_d = level_q;
      endcase
      if (TX_OVF_CLR) begin
         ovf_d = 1'b0;
      end
      if (push_req & full & ~pop_ok) begin
         ovf_d = 1'b1;
      end
      intr_d = TX_INTR_EN & (level_d <= TX_WMARK);
   end

   // State registers with synchronous clear.
   always_ff @(posedge PCLK_TX) begin
      if (CLEAR_TX) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         intr_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         intr_q   <= intr_d;
      end
   end

   assign TX_VALID  = ~empty;
   assign TX_FULL   = full;
   assign TX_LEVEL  = level_q;
   assign TxData    = TX_VALID ? head : '0;
   assign SSPTXINTR = intr_q;
   assign TX_OVF    = ovf_q;

endmodule

// File: tb/tb_ssp_tx_fifo_param.sv
// Directed testbench for ssp_tx_fifo_param (DATA_W=8, DEPTH=8).
// Table-driven vectors plus wrap and mid-operation reset sequences.
module tb_ssp_tx_fifo_param;

   localparam int DW = 8;
   localparam int DP = 8;

   logic          clk = 1'b0;
   logic          clr;
   logic          psel;
   logic          pwrite;
   logic [DW-1:0] wdata;
   logic          rd;
   logic [3:0]    wmark;
   logic          inten;
   logic          oclr;
   logic [DW-1:0] txdata;
   logic          valid;
   logic          full;
   logic [3:0]    level;
   logic          intr;
   logic          ovf;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ssp_tx_fifo_param #(.DATA_W(DW), .DEPTH(DP)) dut (
      .PCLK_TX    (clk),
      .CLEAR_TX   (clr),
      .PSEL_TX    (psel),
      .PWRITE_TX  (pwrite),
      .PWDATA_TX  (wdata),
      .TX_RD      (rd),
      .TX_WMARK   (wmark),
      .TX_INTR_EN (inten),
      .TX_OVF_CLR (oclr),
      .TxData     (txdata),
      .TX_VALID   (valid),
      .TX_FULL    (full),
      .TX_LEVEL   (level),
      .SSPTXINTR  (intr),
      .TX_OVF     (ovf)
   );

   typedef struct {
      logic       clr;
      logic       sel;
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic [3:0] wm;
      logic       en;
      logic       oclr;
      logic [7:0] e_data;
      logic       e_valid;
      logic       e_full;
      logic [3:0] e_level;
      logic       e_intr;
      logic       e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic c, input logic s, input logic w, input logic [7:0] d,
      input logic r, input logic [3:0] m, input logic e, input logic o,
      input logic [7:0] xd, input logic xv, input logic xf,
      input logic [3:0] xl, input logic xi, input logic xo);
      vec_t t;
      t.clr = c; t.sel = s; t.wr = w; t.wd = d; t.rd = r;
      t.wm = m; t.en = e; t.oclr = o;
      t.e_data = xd; t.e_valid = xv; t.e_full = xf;
      t.e_level = xl; t.e_intr = xi; t.e_ovf = xo;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic c, input logic s, input logic w,
                        input logic [7:0] d, input logic r,
                        input logic [3:0] m, input logic e, input logic o);
      clr = c; psel = s; pwrite = w; wdata = d; rd = r;
      wmark = m; inten = e; oclr = o;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input vec_t t);
      chk({tag, " data"},  32'(txdata), 32'(t.e_data));
      chk({tag, " valid"}, 32'(valid),  32'(t.e_valid));
      chk({tag, " full"},  32'(full),   32'(t.e_full));
      chk({tag, " level"}, 32'(level),  32'(t.e_level));
      chk({tag, " intr"},  32'(intr),   32'(t.e_intr));
      chk({tag, " ovf"},   32'(ovf),    32'(t.e_ovf));
   endtask

   // Scoreboard for the wrap sequence
   logic [7:0] q[$];

   initial begin
      clr = 1'b1; psel = 1'b0; pwrite = 1'b0; wdata = '0; rd = 1'b0;
      wmark = 4'd3; inten = 1'b1; oclr = 1'b0;

      // reset held 2 cycles with pushes, then release
      vecs.push_back(mk(1,1,1,8'h77,0,3,1,0, 8'h00,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,8'h78,0,3,1,0, 8'h00,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,8'h00,0,3,1,0, 8'h00,0,0,0,1,0));
      // fill with watermark 3
      vecs.push_back(mk(0,1,1,8'h01,0,3,1,0, 8'h01,1,0,1,1,0));
      vecs.push_back(mk(0,1,1,8'h02,0,3,1,0, 8'h01,1,0,2,1,0));
      vecs.push_back(mk(0,1,1,8'h03,0,3,1,0, 8'h01,1,0,3,1,0));
      vecs.push_back(mk(0,1,1,8'h04,0,3,1,0, 8'h01,1,0,4,0,0));
      vecs.push_back(mk(0,1,0,8'hEE,0,3,1,0, 8'h01,1,0,4,0,0));
      vecs.push_back(mk(0,1,1,8'h05,0,3,1,0, 8'h01,1,0,5,0,0));
      vecs.push_back(mk(0,1,1,8'h06,0,3,1,0, 8'h01,1,0,6,0,0));
      vecs.push_back(mk(0,1,1,8'h07,0,3,1,0, 8'h01,1,0,7,0,0));
      vecs.push_back(mk(0,1,1,8'h08,0,3,1,0, 8'h01,1,1,8,0,0));
      // overflow, clear, clear+overflow
      vecs.push_back(mk(0,1,1,8'hAA,0,3,1,0, 8'h01,1,1,8,0,1));
      vecs.push_back(mk(0,0,0,8'h00,0,3,1,1, 8'h01,1,1,8,0,0));
      vecs.push_back(mk(0,1,1,8'hBB,0,3,1,1, 8'h01,1,1,8,0,1));
      vecs.push_back(mk(0,0,0,8'h00,0,3,1,1, 8'h01,1,1,8,0,0));
      // full push+pop
      vecs.push_back(mk(0,1,1,8'h55,1,3,1,0, 8'h02,1,1,8,0,0));
      // drain
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h03,1,0,7,0,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h04,1,0,6,0,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h05,1,0,5,0,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h06,1,0,4,0,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h07,1,0,3,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h08,1,0,2,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h55,1,0,1,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h00,0,0,0,1,0));
      // pop on empty ignored
      vecs.push_back(mk(0,0,0,8'h00,1,3,1,0, 8'h00,0,0,0,1,0));
      // push+pop on empty
      vecs.push_back(mk(0,1,1,8'h99,1,3,1,0, 8'h99,1,0,1,1,0));
      vecs.push_back(mk(0,0,0,8'h00,1,3,0,0, 8'h00,0,0,0,0,0));
      // watermark extremes
      vecs.push_back(mk(0,0,0,8'h00,0,0,1,0, 8'h00,0,0,0,1,0));
      vecs.push_back(mk(0,1,1,8'h11,0,0,1,0, 8'h11,1,0,1,0,0));
      vecs.push_back(mk(0,0,0,8'h00,0,8,1,0, 8'h11,1,0,1,1,0));
      // reset with push and pop pending
      vecs.push_back(mk(1,1,1,8'h22,1,8,1,0, 8'h00,0,0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].clr, vecs[i].sel, vecs[i].wr, vecs[i].wd,
               vecs[i].rd, vecs[i].wm, vecs[i].en, vecs[i].oclr);
         chk_all($sformatf("vec%0d", i), vecs[i]);
      end

      // WMARK=DEPTH keeps interrupt asserted even when full
      drive(0,0,0,8'h00,0,4'd8,1,0);
      for (int i = 0; i < DP; i++) begin
         drive(0,1,1,8'(8'h30 + i),0,4'd8,1,0);
      end
      chk("wm8 full", 32'(full), 32'd1);
      chk("wm8 intr", 32'(intr), 32'd1);

      // interleaved push/pop across pointer wrap against a queue model
      drive(1,0,0,8'h00,0,4'd3,0,1);
      q.delete();
      for (int i = 0; i < 40; i++) begin
         logic p, r, pop_ok, push_ok;
         logic [7:0] d;
         p = (i % 3) != 2;
         r = (i % 2) == 1;
         d = 8'(8'hC0 + i);
         pop_ok = r && (q.size() > 0);
         push_ok = p && ((q.size() < DP) || pop_ok);
         drive(0,p,p,d,r,4'd3,0,0);
         if (pop_ok) void'(q.pop_front());
         if (push_ok) q.push_back(d);
         chk($sformatf("wrap%0d level", i), 32'(level), 32'(q.size()));
         chk($sformatf("wrap%0d data", i), 32'(txdata),
             q.size() > 0 ? 32'(q[0]) : 32'd0);
      end

      // mid-operation reset at level 5
      drive(1,0,0,8'h00,0,4'd3,0,1);
      for (int i = 0; i < 5; i++) begin
         drive(0,1,1,8'(8'h60 + i),0,4'd3,0,0);
      end
      chk("pre-clr level", 32'(level), 32'd5);
      drive(1,1,1,8'hEE,1,4'd3,0,0);
      chk("clr level", 32'(level), 32'd0);
      chk("clr valid", 32'(valid), 32'd0);
      chk("clr data", 32'(txdata), 32'd0);
      drive(0,1,1,8'h3C,0,4'd3,0,0);
      chk("post-clr data", 32'(txdata), 32'h3C);
      chk("post-clr level", 32'(level), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
